// File: rtl/coord_scan_ctrl_pkg.sv
// coord_scan_pkg: shared types and constants for the coordinate raster sequencer.
package coord_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    // Avalon word addresses
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_WIDTH  = 2'd1;
    localparam logic [1:0] ADDR_HEIGHT = 2'd2;
    localparam logic [1:0] ADDR_POS    = 2'd3;

    // CTRL write bits
    localparam int CTRL_START    = 0;
    localparam int CTRL_ABORT    = 1;
    localparam int CTRL_DONE_CLR = 2;
    localparam int CTRL_IRQ_EN   = 3;

    // STATUS read bits
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;

    // POS register: y sits at this bit offset
    localparam int POS_Y_LSB = 16;

endpackage

// File: rtl/coord_scan_ctrl_if.sv
// coord_scan_if: Avalon-MM register port plus the coordinate stream of coord_scan_ctrl.
interface coord_scan_if #(
    parameter int COORD_W = 10,
    parameter int DATA_W  = 32
);
    logic [1:0]         address;
    logic               write;
    logic [DATA_W-1:0]  writedata;
    logic [DATA_W-1:0]  readdata;
    logic               coord_valid;
    logic               coord_ready;
    logic [COORD_W-1:0] x_coord;
    logic [COORD_W-1:0] y_coord;
    logic               coord_eol;
    logic               coord_last;
    logic               busy;

    modport slave (
        input  address, write, writedata, coord_ready,
        output readdata, coord_valid, x_coord, y_coord, coord_eol, coord_last, busy
    );

    modport master (
        output address, write, writedata, coord_ready,
        input  readdata, coord_valid, x_coord, y_coord, coord_eol, coord_last, busy
    );
endinterface

// File: rtl/coord_scan_ctrl_counter.sv
// coord_scan_counter: x/y raster counter; wraps x at width-1 and steps y.
// The frame end is decided by the owner; advance is never asserted on the last beat.
module coord_scan_counter #(
    parameter int COORD_W = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               advance,
    input  logic [COORD_W-1:0] width,
    input  logic [COORD_W-1:0] height,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               eol,
    output logic               last
);

    assign eol  = (x == width - COORD_W'(1));
    assign last = eol && (y == height - COORD_W'(1));

    // Raster position: clear to origin, otherwise step one column (or wrap to next row)
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (eol) begin
                x <= '0;
                y <= y + COORD_W'(1);
            end else begin
                x <= x + COORD_W'(1);
            end
        end
    end

endmodule

// File: rtl/coord_scan_ctrl.sv
// coord_scan_ctrl: Avalon-MM programmed raster sequencer emitting (x,y) over valid/ready.
// Optional feature macro: COORD_SCAN_IRQ_EN adds the irq port and CTRL bit3 IRQ_EN.
module coord_scan_ctrl
    import coord_scan_pkg::*;
#(
    parameter int COORD_W = 10,
    parameter int DATA_W  = 32
) (
    input  logic        clk,
    input  logic        reset,
`ifdef COORD_SCAN_IRQ_EN
    output logic        irq,
`endif
    coord_scan_if.slave bus
);

    scan_state_t        state;
    logic [COORD_W-1:0] width_r, height_r;
    logic               done_r, valid_r, busy_r, irq_en_r;
    logic [DATA_W-1:0]  rdata_r;
    logic               ctrl_wr, start, abort, done_clr, dims_ok, fire;
    logic [COORD_W-1:0] x, y;
    logic               eol, last;
    logic               unused_wdata;

    assign unused_wdata = ^bus.writedata;

    assign ctrl_wr  = bus.write && (bus.address == ADDR_CTRL);
    assign start    = ctrl_wr && bus.writedata[CTRL_START];
    assign abort    = ctrl_wr && bus.writedata[CTRL_ABORT];
    assign done_clr = ctrl_wr && bus.writedata[CTRL_DONE_CLR];
    assign dims_ok  = (width_r != '0) && (height_r != '0);
    // An abort cycle never completes a handshake
    assign fire     = valid_r && bus.coord_ready && !abort;

    coord_scan_counter #(.COORD_W(COORD_W)) u_counter (
        .clk     (clk),
        .reset   (reset),
        .clear   ((state == IDLE) && start && !abort && dims_ok),
        .advance (fire && !last),
        .width   (width_r),
        .height  (height_r),
        .x       (x),
        .y       (y),
        .eol     (eol),
        .last    (last)
    );

    // Scan FSM; done set events are evaluated after DONE_CLR so set wins
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            if (done_clr) done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        if (dims_ok) begin
                            state   <= RUN;
                            valid_r <= 1'b1;
                            busy_r  <= 1'b1;
                            done_r  <= 1'b0;
                        end else begin
                            done_r  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state   <= IDLE;
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end else if (fire && last) begin
                        state   <= DONE;
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Frame size registers; frozen while a scan is running
    always_ff @(posedge clk) begin
        if (reset) begin
            width_r  <= '0;
            height_r <= '0;
        end else if (bus.write && !busy_r) begin
            if (bus.address == ADDR_WIDTH)  width_r  <= bus.writedata[COORD_W-1:0];
            if (bus.address == ADDR_HEIGHT) height_r <= bus.writedata[COORD_W-1:0];
        end
    end

`ifdef COORD_SCAN_IRQ_EN
    // Interrupt enable and registered level interrupt
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en_r <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en_r <= bus.writedata[CTRL_IRQ_EN];
            irq <= done_r && irq_en_r;
        end
    end
`else
    assign irq_en_r = 1'b0;
`endif

    // Read mux registered every cycle from address (no read strobe)
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_r <= '0;
        end else begin
            rdata_r <= '0;
            case (bus.address)
                ADDR_CTRL: begin
                    rdata_r[STAT_BUSY]   <= busy_r;
                    rdata_r[STAT_DONE]   <= done_r;
                    rdata_r[CTRL_IRQ_EN] <= irq_en_r;
                end
                ADDR_WIDTH:  rdata_r[COORD_W-1:0] <= width_r;
                ADDR_HEIGHT: rdata_r[COORD_W-1:0] <= height_r;
                ADDR_POS: begin
                    rdata_r[POS_Y_LSB +: COORD_W] <= y;
                    rdata_r[COORD_W-1:0]          <= x;
                end
                default: ;
            endcase
        end
    end

    assign bus.readdata    = rdata_r;
    assign bus.coord_valid = valid_r;
    assign bus.busy        = busy_r;
    assign bus.x_coord     = x;
    assign bus.y_coord     = y;
    assign bus.coord_eol   = eol;
    assign bus.coord_last  = last;

endmodule

// File: tb/tb_coord_scan_ctrl.sv
// tb_coord_scan_ctrl: randomized/directed bench with a queue-based raster model.
module tb_coord_scan_ctrl;
    import coord_scan_pkg::*;

    localparam int CW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    coord_scan_if #(.COORD_W(CW), .DATA_W(DW)) bus ();

`ifdef COORD_SCAN_IRQ_EN
    logic irq;
`endif

    coord_scan_ctrl #(.COORD_W(CW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef COORD_SCAN_IRQ_EN
        .irq   (irq),
`endif
        .bus   (bus)
    );

    typedef struct packed {
        logic          last;
        logic          eol;
        logic [CW-1:0] y;
        logic [CW-1:0] x;
    } beat_t;

    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;
    int    rmode  = 0;
    logic  ready_manual = 1'b0;
    int    nbeats = 0;
    beat_t expq[$];
    beat_t log_q[$];

    // Hand-computed 3x2 frame
    int pin_x[6] = '{0, 1, 2, 0, 1, 2};
    int pin_y[6] = '{0, 0, 0, 1, 1, 1};
    int pin_e[6] = '{0, 0, 1, 0, 0, 1};
    int pin_l[6] = '{0, 0, 0, 0, 0, 1};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected frame: every coordinate in raster order
    task automatic build(input int w, input int h);
        beat_t b;
        expq.delete();
        for (int yy = 0; yy < h; yy++)
            for (int xx = 0; xx < w; xx++) begin
                b = {(xx == w - 1) && (yy == h - 1), xx == w - 1, CW'(yy), CW'(xx)};
                expq.push_back(b);
            end
    endtask

    // Ready driver, applied 2 time units after each edge
    initial begin
        bus.coord_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rmode)
                0:       bus.coord_ready = 1'b1;
                1:       bus.coord_ready = ~bus.coord_ready;
                2:       bus.coord_ready = 1'($urandom_range(0, 1));
                default: bus.coord_ready = ready_manual;
            endcase
        end
    end

    // Compare process: every accepted beat against the model queue, plus stall hold
    logic          stall_q = 1'b0;
    logic [CW-1:0] px, py;
    always @(negedge clk) begin
        beat_t e, g;
        if (reset || !mon_en) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q)
                chk("stall_hold", {bus.coord_valid, bus.y_coord, bus.x_coord}, {1'b1, py, px});
            if (expq.size() == 0) begin
                chk("no_beat_expected", bus.coord_valid, 1'b0);
            end else if (bus.coord_valid && bus.coord_ready) begin
                e = expq.pop_front();
                g = {bus.coord_last, bus.coord_eol, bus.y_coord, bus.x_coord};
                chk("beat", g, e);
                log_q.push_back(g);
                nbeats++;
            end
            stall_q = bus.coord_valid && !bus.coord_ready;
            px = bus.x_coord;
            py = bus.y_coord;
        end
    end

    task automatic avm_write(input logic [1:0] a, input logic [31:0] d);
        bus.address = a; bus.write = 1'b1; bus.writedata = d;
        @(posedge clk); #1;
        bus.write = 1'b0; bus.writedata = '0;
    endtask

    task automatic avm_read(input logic [1:0] a, output logic [31:0] d);
        bus.address = a;
        @(posedge clk); #1;
        d = bus.readdata;
    endtask

    task automatic start_scan(input int w, input int h, input logic [31:0] ctrl_extra);
        avm_write(ADDR_WIDTH, w);
        avm_write(ADDR_HEIGHT, h);
        build(w, h);
        log_q.delete();
        nbeats = 0;
        mon_en = 1'b1;
        avm_write(ADDR_CTRL, 32'h1 | ctrl_extra);
        chk("first_valid", bus.coord_valid, (w * h) != 0);
        chk("busy_start", bus.busy, (w * h) != 0);
    endtask

    task automatic wait_scan(input int w, input int h);
        int n = 0;
        int lim = w * h * 4 + 20;
        while ((expq.size() != 0 || bus.busy || bus.coord_valid) && n < lim) begin
            @(posedge clk); #1;
            n++;
        end
        chk("scan_in_budget", n < lim, 1'b1);
        chk("beat_count", nbeats, w * h);
        chk("busy_end", bus.busy, 1'b0);
    endtask

    task automatic check_pins();
        chk("pin_count", log_q.size(), 6);
        for (int i = 0; i < 6 && i < log_q.size(); i++) begin
            chk("pin_x", log_q[i].x, pin_x[i]);
            chk("pin_y", log_q[i].y, pin_y[i]);
            chk("pin_eol", log_q[i].eol, pin_e[i]);
            chk("pin_last", log_q[i].last, pin_l[i]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int w, h;
        bus.address = '0; bus.write = 1'b0; bus.writedata = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_readdata", bus.readdata, 0);
        chk("rst_valid", bus.coord_valid, 0);
        chk("rst_x", bus.x_coord, 0);
        chk("rst_y", bus.y_coord, 0);
        chk("rst_eol", bus.coord_eol, 0);
        chk("rst_last", bus.coord_last, 0);
        chk("rst_busy", bus.busy, 0);
        reset = 1'b0;
        avm_read(ADDR_WIDTH, rd);  chk("rst_width", rd, 0);
        avm_read(ADDR_HEIGHT, rd); chk("rst_height", rd, 0);
        avm_read(ADDR_CTRL, rd);   chk("rst_ctrl", rd, 0);

        // 3x2 with ready held high
        rmode = 0;
        start_scan(3, 2, 0);
        wait_scan(3, 2);
        check_pins();
        avm_read(ADDR_CTRL, rd); chk("status_done", rd, 32'h2);
        avm_read(ADDR_POS, rd);  chk("pos_final", rd, 32'h0001_0002);
        avm_write(ADDR_CTRL, 32'h4);
        avm_read(ADDR_CTRL, rd); chk("done_clr", rd, 0);

        // same frame, ready toggling
        rmode = 1;
        start_scan(3, 2, 0);
        wait_scan(3, 2);
        check_pins();
        avm_write(ADDR_CTRL, 32'h4);

        // zero width: no beats, done immediately
        rmode = 0;
        start_scan(0, 2, 0);
        avm_read(ADDR_CTRL, rd); chk("zero_dim_done", rd, 32'h2);
        repeat (4) @(posedge clk);
        #1;
        chk("zero_dim_beats", nbeats, 0);
        chk("zero_dim_busy", bus.busy, 0);
        avm_write(ADDR_CTRL, 32'h4);

        // abort at (1,0) with ready high in the abort cycle
        rmode = 4; ready_manual = 1'b0;
        start_scan(4, 3, 0);
        ready_manual = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b0;
        avm_write(ADDR_CTRL, 32'h2);
        chk("abort_valid", bus.coord_valid, 0);
        chk("abort_x_held", bus.x_coord, 1);
        chk("abort_busy", bus.busy, 0);
        avm_read(ADDR_CTRL, rd); chk("abort_status", rd, 0);
        avm_write(ADDR_CTRL, 32'h3);
        chk("abort_start_valid", bus.coord_valid, 0);
        avm_read(ADDR_CTRL, rd); chk("abort_start_status", rd, 0);
        rmode = 0; ready_manual = 1'b0;
        start_scan(4, 3, 0);
        chk("restart_xy", {bus.y_coord, bus.x_coord}, 0);
        wait_scan(4, 3);
        avm_write(ADDR_CTRL, 32'h4);

        // writes during RUN are ignored
        rmode = 1;
        start_scan(3, 2, 0);
        avm_write(ADDR_WIDTH, 5);
        avm_write(ADDR_CTRL, 32'h1);
        wait_scan(3, 2);
        check_pins();
        avm_read(ADDR_WIDTH, rd); chk("width_kept", rd, 3);
        avm_write(ADDR_CTRL, 32'h4);

        // only COORD_W bits are stored
        avm_write(ADDR_WIDTH, 32'hFFFF_FC03);
        avm_read(ADDR_WIDTH, rd); chk("width_mask", rd, 3);

        // DONE_CLR in the same cycle as the final beat: set wins
        rmode = 4; ready_manual = 1'b0;
        start_scan(1, 1, 0);
        ready_manual = 1'b1;
        avm_write(ADDR_CTRL, 32'h4);
        wait_scan(1, 1);
        avm_read(ADDR_CTRL, rd); chk("set_wins", rd, 32'h2);
        rmode = 0; ready_manual = 1'b0;
        avm_write(ADDR_CTRL, 32'h4);

        // maximum width, random ready
        rmode = 2;
        start_scan(1023, 2, 0);
        wait_scan(1023, 2);
        avm_read(ADDR_POS, rd); chk("pos_max", rd, 32'h0001_03FE);
        avm_write(ADDR_CTRL, 32'h4);

        // random frames and ready patterns
        for (int i = 0; i < 8; i++) begin
            w = $urandom_range(1, 6);
            h = $urandom_range(1, 5);
            rmode = $urandom_range(0, 2);
            start_scan(w, h, 0);
            wait_scan(w, h);
            avm_write(ADDR_CTRL, 32'h4);
        end

        // reset mid-scan
        rmode = 0;
        start_scan(5, 5, 0);
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_valid", bus.coord_valid, 0);
        chk("midrst_xy", {bus.y_coord, bus.x_coord}, 0);
        chk("midrst_busy", bus.busy, 0);
        reset = 1'b0;
        avm_read(ADDR_WIDTH, rd); chk("midrst_width", rd, 0);

`ifdef COORD_SCAN_IRQ_EN
        start_scan(1, 1, 32'h8);
        wait_scan(1, 1);
        @(posedge clk); #1;
        chk("irq_set", irq, 1);
        avm_write(ADDR_CTRL, 32'hC);
        chk("irq_lag", irq, 1);
        @(posedge clk); #1;
        chk("irq_clr", irq, 0);
        avm_read(ADDR_CTRL, rd); chk("irq_en_read", rd, 32'h8);
`else
        avm_write(ADDR_CTRL, 32'h8);
        avm_read(ADDR_CTRL, rd); chk("bit3_reads_0", rd, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
